// File: rtl/cmp4_bist_ctrl.sv
// Built-in self-test sequencer for a 4-bit magnitude comparator.
// Sweeps all 256 (A, B) pairs, checks each result against a golden compare and records failures.
module cmp4_bist_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] A,
    output logic [3:0] B,
    input  logic       A_lt_B,
    input  logic       A_gt_B,
    input  logic       A_eq_B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_cnt,
    output logic       fail_valid,
    output logic [3:0] fail_A,
    output logic [3:0] fail_B
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [2:0] golden;
    logic [2:0] observed;
    logic       mismatch;
    logic       last_pair;
    logic [8:0] err_next;

    always_comb begin
        golden    = {A < B, A > B, A == B};
        observed  = {A_lt_B, A_gt_B, A_eq_B};
        mismatch  = (golden != observed);
        last_pair = (A == 4'hF) && (B == 4'hF);
        err_next  = err_cnt + 9'(mismatch);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            A          <= '0;
            B          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_A     <= '0;
            fail_B     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_SETTLE;
                        cnt        <= '0;
                        A          <= '0;
                        B          <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_cnt    <= '0;
                        fail_valid <= 1'b0;
                        fail_A     <= '0;
                        fail_B     <= '0;
                    end
                end
                S_SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    err_cnt <= err_next;
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_A     <= A;
                        fail_B     <= B;
                    end
                    if (last_pair) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        state <= S_SETTLE;
                        cnt   <= '0;
                        // B is the low nibble, so its 15->0 wrap carries into A.
                        {A, B} <= {A, B} + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cmp4_bist_ctrl.md
# cmp4_bist_ctrl

Built-in self-test sequencer for the 4-bit magnitude comparator (ports A3..A0, B3..B0, A_lt_B, A_gt_B, A_eq_B).
- On `start`, it drives all 256 (A, B) operand pairs into one comparator instance and samples the three outputs after a programmable settle time.
- It checks each result against an internal golden model, counts mismatches, and latches the first failing pair.
- It sits beside the comparator in the lab top level and replaces the simulation-only exhaustive loop with synthesizable on-board self-test.

## Interface
Parameters:
- `SETTLE`, default 1: clock cycles that each operand pair is held before sampling. Legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a test run. Honoured only in IDLE or DONE.
- `A`  out  4  operand A to the comparator; bit k drives Ak.
- `B`  out  4  operand B to the comparator; bit k drives Bk.
- `A_lt_B`  in  1  comparator output under test.
- `A_gt_B`  in  1  comparator output under test.
- `A_eq_B`  in  1  comparator output under test.
- `busy`  out  1  high while in SETTLE or CHECK.
- `done`  out  1  high while in DONE.
- `pass`  out  1  equals `done` AND (`err_cnt` == 0).
- `err_cnt`  out  9  number of mismatching pairs, 0..256. No wrap is possible.
- `fail_valid`  out  1  a first failure has been latched.
- `fail_A`  out  4  A of the first failing pair.
- `fail_B`  out  4  B of the first failing pair.

## Operation
States: IDLE, SETTLE, CHECK, DONE.
- **IDLE:** outputs hold reset values. On `start`=1, go to SETTLE.
  - On entry to SETTLE: A=0, B=0, settle counter=0, `err_cnt`=0, `fail_valid`=0, `fail_A`=0, `fail_B`=0.
- **SETTLE:** A and B are held.
  - The counter increments each cycle.
  - When the counter reaches SETTLE-1, go to CHECK.
- **CHECK:** one cycle. The comparator outputs are sampled at the end of this cycle.
  - Golden values: lt=(A<B), gt=(A>B), eq=(A==B), unsigned 4-bit.
  - A mismatch is any of the three sampled bits differing from golden. This includes non-one-hot patterns such as 000 or 111.
  - On mismatch: `err_cnt` += 1. If `fail_valid`=0, latch `fail_A`=A, `fail_B`=B and set `fail_valid`=1.
  - If A=15 and B=15, go to DONE. Otherwise advance and return to SETTLE with the counter at 0.
  - Advance order: B increments first. When B wraps 15->0, A increments. The sequence is (0,0),(0,1)..(0,15),(1,0)..(15,15).
- **DONE:**
  - A and B hold 15, 15.
  - The results hold until the next run or reset.
  - `start`=1 restarts exactly as from IDLE, with results cleared on SETTLE entry.
- `start` in SETTLE or CHECK is ignored. No restart and no effect on results.
- Reset (`rst_n`=0 at a clock edge), in any state including mid-run: go to IDLE, and drive all outputs to reset values on that edge.

## Timing
- Reset values: all outputs 0. This means A=0, B=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_valid`=0, `fail_A`=0, `fail_B`=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Each pair occupies SETTLE+1 cycles: SETTLE cycles in SETTLE plus 1 cycle in CHECK.
- A and B change only on the edge that enters SETTLE.
- Let edge 0 be the edge that accepts `start`.
  - `busy` is high from edge 0.
  - `done` rises at edge 256·(SETTLE+1). For SETTLE=1 this is 512.
  - `busy` falls on the same edge that `done` rises.
- The `err_cnt` and `fail_*` updates for the last pair land on the same edge as `done` rising. `pass` is therefore valid on the first `done` cycle.
- With `start` held high continuously: one restart per entry to DONE.
  - DONE lasts exactly 1 cycle before restarting, since `start` is sampled in DONE.

## Test plan
- **Correct comparator model, SETTLE=1, 1-cycle `start` pulse:** `done`=1 exactly 512 cycles after the start edge; `pass`=1, `err_cnt`=0, `fail_valid`=0; A/B trace the 256 pairs in B-major-inner order.
- **Model with A_eq_B stuck at 0:** `err_cnt`=16, `fail_valid`=1, `fail_A`=0, `fail_B`=0, `pass`=0.
- **Model wrong only at (5,9), reporting gt=1, lt=0:** `err_cnt`=1, `fail_A`=5, `fail_B`=9. Also model all-ones output only at (3,3): `err_cnt`=1, `fail_A`=3, `fail_B`=3.
- **Faulty run, then restart:** after a faulty run, swap to a correct model and pulse `start` in DONE. `err_cnt` and `fail_valid` clear on the start edge, and the run ends with `pass`=1. Pulses of `start` mid-run do not shift `done` timing.
- **Reset mid-run:** assert `rst_n`=0 for one edge at cycle 100 of a run. All outputs are 0 the next cycle and the state is IDLE. A new `start` produces a full 512-cycle run.
- **SETTLE=3, with a comparator model whose outputs lag operands by 2 cycles:** `pass`=1 and `done` at cycle 1024. The same lagged model with SETTLE=1 gives `pass`=0 and `err_cnt`>0.
